// File: rtl/prog_counter_pkg.sv
// rtl/prog_counter_pkg.sv - shared state encoding and mode constants for prog_counter
package prog_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/prog_counter.sv
// rtl/prog_counter.sv - loadable terminal-count counter, one-shot or auto-reload
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit DONE_PULSE = 1'b0
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             ldEn,
  input  logic [WIDTH-1:0] value,
  input  logic             mode,
  input  logic             cEn,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             cO,
  output logic             cDone,
  output logic             wrap,
  output logic             busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_target;
  logic             r_mode;
  logic             r_done;
  logic             r_wrap;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_target_nxt;
  logic             w_mode_nxt;
  logic             w_done_nxt;
  logic             w_wrap_nxt;

  logic             w_busy;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_count_inc;

  assign w_busy      = (r_state == ST_ARMED) || (r_state == ST_RUN);
  assign w_accept    = cEn && w_busy;
  // One extra bit so a target of 2^WIDTH-1 is reached without rollover
  assign w_count_inc = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
  assign w_last      = (w_count_inc == {1'b0, r_target});

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_target <= '0;
      r_mode   <= MODE_ONESHOT;
      r_done   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_target <= w_target_nxt;
      r_mode   <= w_mode_nxt;
      r_done   <= w_done_nxt;
      r_wrap   <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_target_nxt = r_target;
    w_mode_nxt   = r_mode;
    w_done_nxt   = DONE_PULSE ? 1'b0 : r_done;
    w_wrap_nxt   = 1'b0;

    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
      w_done_nxt  = 1'b0;
    end else if (ldEn) begin
      w_target_nxt = value;
      w_mode_nxt   = mode ? MODE_RELOAD : MODE_ONESHOT;
      w_count_nxt  = '0;
      // A zero-length load finishes immediately in either mode
      if (value == '0) begin
        w_state_nxt = ST_DONE;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = ST_ARMED;
        w_done_nxt  = 1'b0;
      end
    end else if (w_accept) begin
      if (!w_last) begin
        w_count_nxt = w_count_inc[WIDTH-1:0];
        w_state_nxt = ST_RUN;
      end else if (r_mode == MODE_RELOAD) begin
        w_count_nxt = '0;
        w_state_nxt = ST_ARMED;
        w_wrap_nxt  = 1'b1;
      end else begin
        w_count_nxt = r_target;
        w_state_nxt = ST_DONE;
        w_done_nxt  = 1'b1;
      end
    end
  end

  assign count = r_count;
  assign cO    = w_accept;
  assign cDone = r_done;
  assign wrap  = r_wrap;
  assign busy  = w_busy;

endmodule

// File: tb/tb_prog_counter.sv
// tb/tb_prog_counter.sv - self-checking bench for prog_counter across three parameter sets
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       ldEn = 1'b0;
  logic [7:0] value = 8'd0;
  logic       mode = 1'b0;
  logic       cEn = 1'b0;
  logic       abort = 1'b0;

  logic [7:0] count0, count1;
  logic [2:0] count2;
  logic       co0, co1, co2, done0, done1, done2, wrap0, wrap1, wrap2, busy0, busy1, busy2;

  always #5 clk = ~clk;

  prog_counter #(.WIDTH(8), .DONE_PULSE(1'b0)) dut0 (
    .clk(clk), .rstN(rstN), .ldEn(ldEn), .value(value), .mode(mode), .cEn(cEn), .abort(abort),
    .count(count0), .cO(co0), .cDone(done0), .wrap(wrap0), .busy(busy0));

  prog_counter #(.WIDTH(8), .DONE_PULSE(1'b1)) dut1 (
    .clk(clk), .rstN(rstN), .ldEn(ldEn), .value(value), .mode(mode), .cEn(cEn), .abort(abort),
    .count(count1), .cO(co1), .cDone(done1), .wrap(wrap1), .busy(busy1));

  prog_counter #(.WIDTH(3), .DONE_PULSE(1'b0)) dut2 (
    .clk(clk), .rstN(rstN), .ldEn(ldEn), .value(value[2:0]), .mode(mode), .cEn(cEn), .abort(abort),
    .count(count2), .cO(co2), .cDone(done2), .wrap(wrap2), .busy(busy2));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one slot per DUT, expressed as "active counter with target"
  int m_count[3];
  int m_target[3];
  bit m_mode[3];
  bit m_busy[3];
  bit m_done[3];
  bit m_wrap[3];

  function automatic int wid(input int k);
    return (k == 2) ? 3 : 8;
  endfunction

  function automatic bit is_pulse(input int k);
    return (k == 1);
  endfunction

  typedef struct {
    bit ld;
    int v;
    bit m;
    bit c;
    bit a;
    int e_cnt;
    bit e_done;
    bit e_wrap;
    bit e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit ld, input int v, input bit m, input bit c, input bit a,
                     input int e_cnt, input bit e_done, input bit e_wrap, input bit e_busy);
    vec_t t;
    t.ld = ld; t.v = v; t.m = m; t.c = c; t.a = a;
    t.e_cnt = e_cnt; t.e_done = e_done; t.e_wrap = e_wrap; t.e_busy = e_busy;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input int k, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  task automatic get_dut(input int k, output int cnt, output int d, output int w,
                         output int b, output int o);
    case (k)
      0: begin cnt = int'(count0); d = int'(done0); w = int'(wrap0); b = int'(busy0); o = int'(co0); end
      1: begin cnt = int'(count1); d = int'(done1); w = int'(wrap1); b = int'(busy1); o = int'(co1); end
      default: begin cnt = int'(count2); d = int'(done2); w = int'(wrap2); b = int'(busy2); o = int'(co2); end
    endcase
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_count[k] = 0; m_target[k] = 0; m_mode[k] = 0;
      m_busy[k] = 0; m_done[k] = 0; m_wrap[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int v;
      v = int'(value) % (1 << wid(k));
      m_wrap[k] = 0;
      if (abort) begin
        m_busy[k] = 0; m_count[k] = 0; m_done[k] = 0;
      end else if (ldEn) begin
        m_target[k] = v; m_mode[k] = mode; m_count[k] = 0;
        m_done[k] = (v == 0);
        m_busy[k] = (v != 0);
      end else begin
        if (is_pulse(k)) m_done[k] = 0;
        if (cEn && m_busy[k]) begin
          if (m_count[k] + 1 < m_target[k]) m_count[k] = m_count[k] + 1;
          else if (m_mode[k]) begin
            m_count[k] = 0; m_wrap[k] = 1;
          end else begin
            m_count[k] = m_target[k]; m_busy[k] = 0; m_done[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    int cnt, d, w, b, o;
    for (int k = 0; k < 3; k++) begin
      get_dut(k, cnt, d, w, b, o);
      check("count", k, cnt, m_count[k]);
      check("cDone", k, d, int'(m_done[k]));
      check("wrap", k, w, int'(m_wrap[k]));
      check("busy", k, b, int'(m_busy[k]));
      check("cO", k, o, int'(cEn && m_busy[k]));
    end
  endtask

  task automatic step(input bit l, input int v, input bit m, input bit c, input bit a);
    ldEn = l; value = v[7:0]; mode = m; cEn = c; abort = a;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int cnt, d, w, b, o;

    // Plan 1: one-shot 5
    add(1, 5, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 7; i++) add(0, 0, 0, 1, 0, (i < 5) ? i : 5, i >= 5, 0, i < 5);
    // Plan 2: auto-reload 3
    add(1, 3, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 9; i++) add(0, 0, 0, 1, 0, i % 3, 0, (i % 3) == 0, 1);
    // Plan 3: paused counting to 4
    add(1, 4, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0, 2, 0, 0, 1);
    add(0, 0, 0, 1, 0, 3, 0, 0, 1);
    add(0, 0, 0, 0, 0, 3, 0, 0, 1);
    add(0, 0, 0, 1, 0, 4, 1, 0, 0);
    // Plan 4: abort beats a simultaneous load
    add(1, 6, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0, 2, 0, 0, 1);
    add(0, 0, 0, 1, 0, 3, 0, 0, 1);
    add(1, 6, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Plan 5: zero-length loads in both modes
    add(1, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0);

    model_reset();
    repeat (2) @(negedge clk);
    check_model();
    rstN = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].v, tbl[i].m, tbl[i].c, tbl[i].a);
      check("tbl_count", i, int'(count0), tbl[i].e_cnt);
      check("tbl_cDone", i, int'(done0), int'(tbl[i].e_done));
      check("tbl_wrap", i, int'(wrap0), int'(tbl[i].e_wrap));
      check("tbl_busy", i, int'(busy0), int'(tbl[i].e_busy));
    end

    // Pulse variant: cDone up for exactly one cycle, level variant holds
    check("pulse_hi", 1, int'(done1), 1);
    step(0, 0, 0, 0, 0);
    check("pulse_lo", 1, int'(done1), 0);
    check("level_hold", 0, int'(done0), 1);
    step(0, 0, 0, 1, 0);
    check("pulse_stay", 1, int'(done1), 0);

    // Plan 6: 3-bit counter reaches its max target without rollover
    step(1, 7, 0, 0, 0);
    repeat (7) step(0, 0, 0, 1, 0);
    check("w3_count", 2, int'(count2), 7);
    check("w3_done", 2, int'(done2), 1);
    check("w3_wrap", 2, int'(wrap2), 0);
    step(1, 6, 0, 0, 0);
    repeat (2) step(0, 0, 0, 1, 0);
    #2 rstN = 1'b0;
    #1 model_reset();
    for (int k = 0; k < 3; k++) begin
      get_dut(k, cnt, d, w, b, o);
      check("async_count", k, cnt, 0);
      check("async_cDone", k, d, 0);
      check("async_busy", k, b, 0);
      check("async_cO", k, o, 0);
      check("async_wrap", k, w, 0);
    end
    @(negedge clk);
    rstN = 1'b1;

    // Full-width target in reload mode
    step(1, 255, 1, 0, 0);
    repeat (255) step(0, 0, 0, 1, 0);
    check("max_wrap", 0, int'(wrap0), 1);
    check("max_count", 0, int'(count0), 0);

    // Randomised traffic against the model, including value/mode churn without loads
    for (int i = 0; i < 600; i++) begin
      bit l, m, c, a;
      int v;
      l = ($urandom_range(0, 9) == 0);
      m = $urandom_range(0, 1) == 1;
      c = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
      step(l, v, m, c, a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
Loadable terminal-count counter with a small control FSM and two modes: one-shot and auto-reload. It is the parametrised successor of the 3-bit load/count/done counter used by the lab state machines. Width is generic, and the block adds reset, abort, a visible count, busy status, and a periodic wrap pulse. The controlling state machine drives ldEn/cEn and waits on cDone (one-shot) or wrap (auto-reload).

Parameters:
WIDTH, 8, bit width of value, internal target and count.
DONE_PULSE, 0, 0 = cDone is a sticky level until the next ldEn/abort; 1 = cDone is a one-cycle pulse.

Ports:
clk  input  1  clock, all state changes on posedge.
rstN  input  1  asynchronous, active-low reset.
ldEn  input  1  load: capture value and mode, clear count, arm.
value  input  WIDTH  terminal count (number of cEn cycles to done).
mode  input  1  0 = one-shot, 1 = auto-reload; sampled only with ldEn.
cEn  input  1  count enable, one increment per cycle while armed/running.
abort  input  1  synchronous cancel: return to IDLE.
count  output  WIDTH  current count (registered).
cO  output  1  combinational: high when an increment is accepted this cycle (cEn && busy).
cDone  output  1  terminal count reached (one-shot mode only).
wrap  output  1  registered one-cycle pulse on each period completion (auto-reload only).
busy  output  1  state is ARMED or RUN.

Behaviour:
- Reset (rstN low, asynchronous): state IDLE; count, target, storedMode, cDone and wrap all 0.
- States:
  - IDLE: no target held.
  - ARMED: loaded, count==0, no increment yet.
  - RUN: count>0, below target.
  - DONE: one-shot finished.
- Per-edge priority: abort > ldEn > cEn.
- abort: go to IDLE; count 0; cDone 0; wrap 0. Any state, including mid-count.
- ldEn (no abort):
  - target<=value, storedMode<=mode, count<=0, cDone<=0.
  - If value!=0, go to ARMED.
  - If value==0 (zero-length), go to DONE and set cDone=1 in the same edge, regardless of mode. Auto-reload with target 0 never wraps.
  - ldEn while ARMED/RUN/DONE restarts cleanly; no increment happens that cycle even if cEn is high.
- cEn in ARMED/RUN (no abort/ldEn):
  - If count+1 != target: count<=count+1, go to RUN.
  - If count+1 == target and one-shot: count<=target, go to DONE, cDone<=1.
  - If count+1 == target and auto-reload: count<=0, go to ARMED, wrap<=1 for exactly the next cycle. cDone stays 0.
- cEn low: count and state hold (pause). No timeout.
- cEn in IDLE or DONE: ignored; count holds; cO=0.
- cDone:
  - DONE_PULSE=0: held in DONE until ldEn/abort.
  - DONE_PULSE=1: high for exactly one cycle after entering DONE; the state stays DONE.
- Latency: cDone/wrap are visible the cycle after the edge on which the final cEn was sampled. Done after N cEn cycles means the N-th accepted increment.
- Width:
  - The count compare uses the full WIDTH with no overflow. Max target 2^WIDTH-1 reaches done with no rollover.
  - count never exceeds target.
  - Changes to value or mode without ldEn have no effect.
- Outputs are registered except cO and busy (busy is decoded from the state register).

Decomposition:
- Shared package prog_counter_pkg:
  - state enum (IDLE, ARMED, RUN, DONE) as a 2-bit encoding.
  - mode constants MODE_ONESHOT=0, MODE_RELOAD=1.
- Single module, no sub-modules. The FSM and datapath are small enough to keep together.

Test Plan:
1. Reset, then ldEn with value=5, mode=0, then cEn high for 7 cycles → cO high for 5 cycles. count steps 1..5, then holds at 5. cDone rises the cycle after the 5th increment and stays high (DONE_PULSE=0).
2. Load value=3, mode=1, cEn held high for 9 cycles → count sequence 1,2,0,1,2,0,1,2,0. wrap pulses 3 times, one cycle each. cDone stays 0. busy stays 1.
3. Load value=4, cEn pattern 1,0,0,1,1,0,1 → count 1,1,1,2,3,3,4. cDone asserts only after the 4th accepted increment.
4. Load value=6, count to 3, then assert abort and ldEn together → state IDLE, count 0, busy 0. The later cEn is ignored.
5. Load value=0 (either mode) → next cycle cDone=1 and busy=0. With DONE_PULSE=1, cDone is high for exactly one cycle.
6. WIDTH=3, load 7 and count to done → count reaches 7 with no wrap and cDone=1. Then assert rstN low asynchronously mid-cycle → all outputs drop to 0 immediately.
